// File: rtl/invader_march_ctrl_pkg.sv
// Shared types and default tuning for the alien-formation march scheduler.
package march_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARCH = 2'd1,
        DROP  = 2'd2,
        HALT  = 2'd3
    } march_state_t;

    localparam int CNT_W_DEF        = 6;
    localparam int MIN_PERIOD_DEF   = 2;
    localparam int PERIOD_SHIFT_DEF = 2;

endpackage

// File: rtl/invader_march_ctrl_if.sv
// Bus between the frame-tick/game-state sources and the march scheduler.
interface invader_march_ctrl_if #(
    parameter int CNT_W = 6
);
    logic             frame_tick;
    logic             start;
    logic             halt_req;
    logic [CNT_W-1:0] alive_count;
    logic             edge_left;
    logic             edge_right;
    logic             step_pulse;
    logic             drop_pulse;
    logic             dir_right;
    logic             anim_phase;
    logic             wave_clear;
    logic             busy;

    modport master (
        output frame_tick, start, halt_req, alive_count, edge_left, edge_right,
        input  step_pulse, drop_pulse, dir_right, anim_phase, wave_clear, busy
    );

    modport slave (
        input  frame_tick, start, halt_req, alive_count, edge_left, edge_right,
        output step_pulse, drop_pulse, dir_right, anim_phase, wave_clear, busy
    );
endinterface

// File: rtl/invader_march_ctrl_period_counter.sv
// Loadable down counter that times frame ticks between formation steps.
module march_period_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic         hold,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);

    // Load wins over everything; hold only suppresses decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !hold && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/invader_march_ctrl.sv
// March scheduler: paces formation steps, edge drops/reversals, freeze and wave clear.
module invader_march_ctrl
    import march_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int MIN_PERIOD   = MIN_PERIOD_DEF,
    parameter int PERIOD_SHIFT = PERIOD_SHIFT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    invader_march_ctrl_if.slave bus
);

    march_state_t     state, state_nxt;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] count;
    logic             cnt_zero;
    logic             cnt_load, cnt_dec;
    logic             step_q, drop_q, wclr_q, dir_q, anim_q;
    logic             step_nxt, drop_nxt, wclr_nxt, dir_nxt, anim_nxt;
    logic             no_aliens, edge_hit;

    // Fewer aliens -> shorter period -> faster march; sampled only on reload.
    assign period    = CNT_W'(MIN_PERIOD) + (bus.alive_count >> PERIOD_SHIFT);
    assign no_aliens = (bus.alive_count == '0);
    assign edge_hit  = (dir_q & bus.edge_right) | (!dir_q & bus.edge_left);

    march_period_counter #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (reset),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .hold     (bus.halt_req),
        .load_val (period),
        .count    (count),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        step_nxt  = 1'b0;
        drop_nxt  = 1'b0;
        wclr_nxt  = 1'b0;
        dir_nxt   = dir_q;
        anim_nxt  = anim_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = MARCH;
                    cnt_load  = 1'b1;
                    dir_nxt   = 1'b1;
                    anim_nxt  = 1'b0;
                end
            end
            MARCH: begin
                if (bus.frame_tick) begin
                    if (no_aliens) begin
                        state_nxt = HALT;
                        wclr_nxt  = 1'b1;
                    end else if (!bus.halt_req) begin
                        if (!cnt_zero) begin
                            cnt_dec = 1'b1;
                        end else begin
                            cnt_load = 1'b1;
                            // Reaching the border replaces the step with a drop.
                            if (edge_hit) begin
                                state_nxt = DROP;
                            end else begin
                                step_nxt = 1'b1;
                                anim_nxt = ~anim_q;
                            end
                        end
                    end
                end
            end
            DROP: begin
                if (bus.frame_tick) begin
                    if (no_aliens) begin
                        state_nxt = HALT;
                        wclr_nxt  = 1'b1;
                    end else if (!bus.halt_req) begin
                        state_nxt = MARCH;
                        drop_nxt  = 1'b1;
                        dir_nxt   = ~dir_q;
                        cnt_load  = 1'b1;
                    end
                end
            end
            HALT: begin
                if (bus.start) begin
                    state_nxt = MARCH;
                    cnt_load  = 1'b1;
                    dir_nxt   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            step_q <= 1'b0;
            drop_q <= 1'b0;
            wclr_q <= 1'b0;
            dir_q  <= 1'b1;
            anim_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            step_q <= step_nxt;
            drop_q <= drop_nxt;
            wclr_q <= wclr_nxt;
            dir_q  <= dir_nxt;
            anim_q <= anim_nxt;
        end
    end

    assign bus.step_pulse = step_q;
    assign bus.drop_pulse = drop_q;
    assign bus.wave_clear = wclr_q;
    assign bus.dir_right  = dir_q;
    assign bus.anim_phase = anim_q;
    assign bus.busy       = (state == MARCH) || (state == DROP);

endmodule

// File: tb/tb_invader_march_ctrl.sv
// Directed bench for the march scheduler with hand-computed step spacing.
module tb_invader_march_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   step_cnt = 0, drop_cnt = 0, wclr_cnt = 0;
    logic last_s, last_d, last_w;

    invader_march_ctrl_if #(.CNT_W(6)) bus ();

    invader_march_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.step_pulse) step_cnt++;
        if (bus.drop_pulse) drop_cnt++;
        if (bus.wave_clear) wclr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; one frame tick every 4 clocks, pulses sampled the cycle after.
    task automatic ftick();
        bus.frame_tick = 1'b1;
        @(negedge clk);
        last_s = bus.step_pulse;
        last_d = bus.drop_pulse;
        last_w = bus.wave_clear;
        bus.frame_tick = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic nticks(input int n);
        for (int i = 0; i < n; i++) ftick();
    endtask

    task automatic ticks_to_step(input int maxn, output int n);
        n = 0;
        last_s = 1'b0;
        for (int i = 0; i < maxn; i++) begin
            ftick();
            n++;
            if (last_s) break;
        end
        if (!last_s) n = -1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int sc;
        reset           = 1'b1;
        bus.frame_tick  = 1'b0;
        bus.start       = 1'b0;
        bus.halt_req    = 1'b0;
        bus.alive_count = 6'd40;
        bus.edge_left   = 1'b0;
        bus.edge_right  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_step", bus.step_pulse, 0);
        chk("rst_drop", bus.drop_pulse, 0);
        chk("rst_wclr", bus.wave_clear, 0);
        chk("rst_dir",  bus.dir_right, 1);
        chk("rst_anim", bus.anim_phase, 0);
        chk("rst_busy", bus.busy, 0);
        reset = 1'b0;
        @(negedge clk);
        nticks(3);
        chk("idle_no_step", step_cnt, 0);

        // 1: P = 2 + 40/4 = 12, steps 13 ticks apart
        pulse_start();
        chk("t1_busy", bus.busy, 1);
        ticks_to_step(40, n);
        chk("t1_first_gap", n, 13);
        chk("t1_anim1", bus.anim_phase, 1);
        ticks_to_step(40, n);
        chk("t1_second_gap", n, 13);
        chk("t1_anim0", bus.anim_phase, 0);
        chk("t1_dir", bus.dir_right, 1);
        chk("t1_step_cnt", step_cnt, 2);

        // 2: right border (left also high, must be ignored while going right)
        nticks(5);
        bus.edge_right = 1'b1;
        bus.edge_left  = 1'b1;
        nticks(7);
        ftick();
        chk("t2_no_step_at_edge", last_s, 0);
        chk("t2_busy_in_drop", bus.busy, 1);
        ftick();
        chk("t2_drop_pulse", last_d, 1);
        chk("t2_dir_left", bus.dir_right, 0);
        bus.edge_right = 1'b0;
        bus.edge_left  = 1'b0;
        chk("t2_drop_cnt", drop_cnt, 1);
        ticks_to_step(40, n);
        chk("t2_gap_after_drop", n, 13);
        chk("t2_anim", bus.anim_phase, 1);

        // wrong-direction edge while marching left
        bus.edge_right = 1'b1;
        ticks_to_step(40, n);
        chk("wrong_edge_gap", n, 13);
        chk("wrong_edge_no_drop", drop_cnt, 1);
        chk("wrong_edge_dir", bus.dir_right, 0);
        bus.edge_right = 1'b0;

        // 3: alive 40 -> 4 mid-count affects only the next reload
        nticks(3);
        bus.alive_count = 6'd4;
        ticks_to_step(40, n);
        chk("t3_rest_of_old", n, 10);
        ticks_to_step(40, n);
        chk("t3_new_gap", n, 4);

        // 4: reload with P=5, then freeze for 20 ticks
        bus.alive_count = 6'd12;
        ticks_to_step(40, n);
        chk("t4_gap_p3", n, 4);
        sc = step_cnt;
        bus.halt_req = 1'b1;
        nticks(20);
        chk("t4_halt_no_steps", step_cnt, sc);
        chk("t4_halt_busy", bus.busy, 1);
        bus.halt_req = 1'b0;
        ticks_to_step(40, n);
        chk("t4_after_release", n, 6);

        // 5: wave clear
        bus.alive_count = 6'd0;
        ftick();
        chk("t5_wclr_pulse", last_w, 1);
        chk("t5_busy", bus.busy, 0);
        sc = step_cnt;
        nticks(5);
        chk("t5_no_steps", step_cnt, sc);
        chk("t5_wclr_once", wclr_cnt, 1);
        chk("t5_dir_held", bus.dir_right, 0);
        bus.alive_count = 6'd40;
        pulse_start();
        chk("t5_restart_busy", bus.busy, 1);
        chk("t5_restart_dir", bus.dir_right, 1);

        // 6: reset on the cycle a step would be decided
        nticks(12);
        sc = step_cnt;
        bus.frame_tick = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        chk("t6_no_step", bus.step_pulse, 0);
        chk("t6_busy", bus.busy, 0);
        chk("t6_dir", bus.dir_right, 1);
        chk("t6_anim", bus.anim_phase, 0);
        bus.frame_tick = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        nticks(15);
        chk("t6_needs_start", step_cnt, sc);
        chk("t6_idle_busy", bus.busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
